// File: rtl/mem_readback_checker.sv
// Read-side scan sequencer for the scratch RAM: walks every address, waits out the read
// latency, presents each word to the display and counts words that differ from exp_base + addr.
module mem_readback_checker #(
    parameter int unsigned AW     = 2,
    parameter int unsigned DW     = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          dir,
    input  logic          go,
    input  logic [DW-1:0] exp_base,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          mismatch,
    output logic [AW:0]   err_count,
    output logic          busy,
    output logic          done
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CNTW  = AW + 1;
    localparam int unsigned LATW  = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state;
    logic            dir_q;
    logic [DW-1:0]   exp_q;
    logic [LATW-1:0] lat_cnt;
    logic [DW-1:0]   expected_c;
    logic            last_addr_c;

    assign expected_c  = exp_q + DW'(rd_addr);
    assign last_addr_c = dir_q ? (rd_addr == '0) : (rd_addr == AW'(DEPTH - 1));

    // Capture lands exactly RD_LAT clocks after the accepted go: the ISSUE->go edge counts as
    // the first latency clock, WAIT covers the remaining RD_LAT-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            dir_q     <= 1'b0;
            exp_q     <= '0;
            lat_cnt   <= '0;
            rd_addr   <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        dir_q     <= dir;
                        exp_q     <= exp_base;
                        rd_addr   <= dir ? AW'(DEPTH - 1) : '0;
                        err_count <= '0;
                        mismatch  <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (go) begin
                        lat_cnt <= LATW'(RD_LAT - 1);
                        state   <= (RD_LAT == 1) ? S_CAPTURE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - LATW'(1);
                    if (lat_cnt == LATW'(1)) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    out_addr  <= rd_addr;
                    out_data  <= rd_data;
                    out_valid <= 1'b1;
                    if (rd_data != expected_c) begin
                        err_count <= err_count + CNTW'(1);
                        mismatch  <= 1'b1;
                    end
                    // Last-address test precedes the step, so rd_addr never wraps.
                    if (last_addr_c) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rd_addr <= dir_q ? (rd_addr - AW'(1)) : (rd_addr + AW'(1));
                        state   <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_readback_checker.sv
// Bench for mem_readback_checker: a word-level scan model checked every cycle, plus
// literal expectations for capture order, error counts and capture timing.
module tb_mem_readback_checker;

    localparam int unsigned AW     = 2;
    localparam int unsigned DW     = 4;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned DEPTH  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic          go = 1'b0;
    logic [DW-1:0] exp_base = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          mismatch;
    logic [AW:0]   err_count;
    logic          busy;
    logic          done;

    mem_readback_checker #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .dir(dir), .go(go),
        .exp_base(exp_base), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid),
        .mismatch(mismatch), .err_count(err_count), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Scratch RAM with one clock of read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) rd_data <= mem[rd_addr];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    bit checking = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Word-level model: a scan is DEPTH words, each issued by the first go seen while
    // waiting, and captured RD_LAT clocks later.
    bit            m_busy, m_done, m_mis, m_wait, m_valid, m_dir;
    int            m_err, m_idx, m_pend;
    logic [DW-1:0] m_base, m_odata;
    logic [AW-1:0] m_oaddr;

    function automatic logic [AW-1:0] addr_of(input bit d, input int i);
        return d ? AW'(DEPTH - 1 - i) : AW'(i);
    endfunction

    always @(posedge clock) begin
        logic [AW-1:0] a;
        m_valid = 0;
        if (reset) begin
            m_busy = 0; m_done = 0; m_mis = 0; m_wait = 0; m_dir = 0;
            m_err = 0; m_idx = 0; m_pend = 0; m_base = '0; m_odata = '0; m_oaddr = '0;
        end else if (!m_busy) begin
            if (start) begin
                m_dir = dir; m_base = exp_base; m_busy = 1; m_done = 0;
                m_err = 0; m_mis = 0; m_idx = 0; m_wait = 1; m_pend = 0;
            end
        end else if (m_wait) begin
            if (go) begin
                m_wait = 0;
                m_pend = RD_LAT;
            end
        end else begin
            m_pend--;
            if (m_pend == 0) begin
                a = addr_of(m_dir, m_idx);
                m_valid = 1; m_oaddr = a; m_odata = mem[a];
                if (mem[a] != DW'(m_base + DW'(a))) begin
                    m_err++;
                    m_mis = 1;
                end
                m_idx++;
                if (m_idx == DEPTH) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_wait = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [AW-1:0] exp_rd;
        if (checking) begin
            exp_rd = (m_busy || m_done) ? addr_of(m_dir, (m_idx > DEPTH - 1) ? DEPTH - 1 : m_idx) : '0;
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_addr", 32'(out_addr), 32'(m_oaddr));
            chk("out_data", 32'(out_data), 32'(m_odata));
            chk("err_count", 32'(err_count), 32'(m_err));
            chk("mismatch", 32'(mismatch), 32'(m_mis));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("rd_addr", 32'(rd_addr), 32'(exp_rd));
        end
    end

    // Capture log for literal expectations.
    int            cap_n = 0;
    int            cap_cyc [8];
    logic [AW-1:0] cap_addr [8];
    logic [DW-1:0] cap_data [8];
    logic          cap_mis [8];

    always @(negedge clock) begin
        if (out_valid === 1'b1 && cap_n < 8) begin
            cap_cyc[cap_n]  = cyc;
            cap_addr[cap_n] = out_addr;
            cap_data[cap_n] = out_data;
            cap_mis[cap_n]  = mismatch;
            cap_n++;
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic load_mem(input logic [DW-1:0] m0, m1, m2, m3);
        mem[0] = m0; mem[1] = m1; mem[2] = m2; mem[3] = m3;
    endtask

    int start_cyc;

    // Start a scan and pace it with go every `period` clocks until done (or stop_caps captures).
    task automatic run_scan(input bit d, input logic [DW-1:0] b, input int period,
                            input bit noise, input int stop_caps);
        bit finished;
        cap_n = 0;
        start = 1; dir = d; exp_base = b; go = (period == 1);
        step();
        start = 0;
        start_cyc = cyc;
        finished = 0;
        for (int t = 0; t < 400; t++) begin
            if (done === 1'b1 || (stop_caps > 0 && cap_n >= stop_caps)) begin
                finished = 1;
                break;
            end
            go = (period == 1) ? 1'b1 : ((t % period) == period - 1);
            start = noise && ((t % 5) == 2);
            if (start) begin
                dir = ~d;
                exp_base = DW'($urandom);
            end
            step();
        end
        go = 0; start = 0;
        chk("scan_finished", 32'(finished), 32'd1);
    endtask

    initial begin
        load_mem(4'h0, 4'h1, 4'h2, 4'h3);
        step(); step();
        reset = 0;
        checking = 1;
        step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rd_addr", 32'(rd_addr), 32'd0);

        // 1: forward, matching pattern
        run_scan(0, 4'h0, 8, 0, 0);
        chk("t1_caps", 32'(cap_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", 32'(cap_addr[i]), 32'(i));
            chk("t1_data", 32'(cap_data[i]), 32'(i));
        end
        chk("t1_err", 32'(err_count), 32'd0);
        chk("t1_mis", 32'(mismatch), 32'd0);
        chk("t1_done", 32'(done), 32'd1);

        // 2: reverse
        run_scan(1, 4'h0, 8, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", 32'(cap_addr[i]), 32'(3 - i));
            chk("t2_data", 32'(cap_data[i]), 32'(3 - i));
        end
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_rd_addr", 32'(rd_addr), 32'd0);

        // 3: reverse with two bad words at addresses 1 and 0
        load_mem(4'h5, 4'h6, 4'h2, 4'h3);
        run_scan(1, 4'h0, 8, 0, 0);
        chk("t3_err", 32'(err_count), 32'd2);
        chk("t3_mis", 32'(mismatch), 32'd1);
        chk("t3_last_data", 32'(out_data), 32'h5);
        chk("t3_mis_a2", 32'(cap_mis[1]), 32'd0);
        chk("t3_mis_a1", 32'(cap_mis[2]), 32'd1);
        chk("t3_mis_a0", 32'(cap_mis[3]), 32'd1);

        // 4: expected pattern wraps mod 16
        load_mem(4'hE, 4'hF, 4'h0, 4'h1);
        run_scan(0, 4'hE, 8, 0, 0);
        chk("t4_err", 32'(err_count), 32'd0);
        chk("t4_mis", 32'(mismatch), 32'd0);
        chk("t4_done", 32'(done), 32'd1);

        // 5: go every clock, including the start clock
        load_mem(4'h0, 4'h1, 4'h2, 4'h3);
        run_scan(0, 4'h0, 1, 0, 0);
        repeat (3) step();
        chk("t5_caps", 32'(cap_n), 32'd4);
        chk("t5_first_cap", 32'(cap_cyc[0] - start_cyc), 32'd2);
        for (int i = 1; i < 4; i++)
            chk("t5_cap_gap", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd2);

        // 6: reset after the second capture, then a fresh scan with start noise while busy
        run_scan(0, 4'h0, 4, 0, 2);
        reset = 1;
        step();
        reset = 0;
        chk("t6_out_addr", 32'(out_addr), 32'd0);
        chk("t6_out_data", 32'(out_data), 32'd0);
        chk("t6_err", 32'(err_count), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        step();
        run_scan(0, 4'h0, 3, 1, 0);
        chk("t6_caps", 32'(cap_n), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t6_addr", 32'(cap_addr[i]), 32'(i));
        chk("t6_final_err", 32'(err_count), 32'd0);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
